adc_capture_writer: RTL and testbench

Upstream feeder for the SDRAM interface. Accepts a stream of 16-bit ADC samples, buffers them in a small FIFO, and writes them to consecutive SDRAM addresses using the interface's Req/WnR/Ack/Busy handshake. A capture of a programmed length is started by a Start pulse. Done reports completion; Overflow reports any dropped samples.

---
 rtl/adc_capture_writer_pkg.sv | 20 ++
 rtl/adc_capture_writer_if.sv | 27 ++
 rtl/adc_capture_writer_sync_fifo.sv | 57 +++++
 rtl/adc_capture_writer.sv | 203 ++++++++++++++++++++
 tb/tb_adc_capture_writer.sv | 365 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adc_capture_writer_pkg.sv
// Shared types and default widths for the ADC capture writer.
package adc_capture_pkg;

  localparam int DATA_W_DEF  = 16;
  localparam int ADDR_W_DEF  = 22;
  localparam int FIFO_AW_DEF = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } cap_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_REQ  = 2'd1,
    W_HOLD = 2'd2
  } wr_state_e;

endpackage

// File: rtl/adc_capture_writer_if.sv
// Write-side handshake to the SDRAM interface (Req/WnR/Ack/Busy/Err).
interface adc_capture_writer_if
  import adc_capture_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic [DATA_W-1:0] MemData;
  logic [ADDR_W-1:0] MemAddress;
  logic              MemReq;
  logic              MemWnR;
  logic              MemBusy;
  logic              MemAck;
  logic              MemErr;

  modport master (
    output MemData, MemAddress, MemReq, MemWnR,
    input  MemBusy, MemAck, MemErr
  );

  modport slave (
    input  MemData, MemAddress, MemReq, MemWnR,
    output MemBusy, MemAck, MemErr
  );

endinterface

// File: rtl/adc_capture_writer_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with a synchronous flush.
module sync_fifo
  import adc_capture_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int FIFO_AW = FIFO_AW_DEF
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               clear_i,
  input  logic               push_i,
  input  logic               pop_i,
  input  logic [DATA_W-1:0]  din_i,
  output logic [DATA_W-1:0]  dout_o,
  output logic               full_o,
  output logic               empty_o,
  output logic [FIFO_AW:0]   count_o
);

  logic [DATA_W-1:0]  mem_q [0:(1<<FIFO_AW)-1];
  logic [FIFO_AW-1:0] rdPtr_q;
  logic [FIFO_AW-1:0] wrPtr_q;
  logic [FIFO_AW:0]   count_q;
  logic               doPush;
  logic               doPop;

  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign doPop   = pop_i && !empty_o;
  assign doPush  = push_i && (!full_o || doPop);
  assign full_o  = count_q[FIFO_AW];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rdPtr_q];

  // Pointer and occupancy tracking; flush and reset both empty the FIFO.
  always_ff @(posedge Clk) begin
    if (Reset || clear_i) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
      if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge Clk) begin
    if (doPush && !Reset && !clear_i) mem_q[wrPtr_q] <= din_i;
  end

endmodule

// File: rtl/adc_capture_writer.sv
// Captures a programmed number of ADC samples and writes them to consecutive SDRAM words.
module adc_capture_writer
  import adc_capture_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int FIFO_AW = FIFO_AW_DEF
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Start_i,
  input  logic [ADDR_W-1:0]   BaseAddr_i,
  input  logic [ADDR_W-1:0]   Length_i,
  input  logic [DATA_W-1:0]   AdcData_i,
  input  logic                AdcValid_i,
  output logic                Active_o,
  output logic                Done_o,
  output logic                Overflow_o,
  output logic                Fault_o,
  output logic [ADDR_W-1:0]   WrCount_o,
  adc_capture_writer_if.master Mem
);

  cap_state_e        capState_q, capState_d;
  wr_state_e         wrState_q, wrState_d;
  logic [ADDR_W-1:0] baseAddr_q, baseAddr_d;
  logic [ADDR_W-1:0] length_q, length_d;
  logic [ADDR_W-1:0] acceptCnt_q, acceptCnt_d;
  logic [ADDR_W-1:0] dropCnt_q, dropCnt_d;
  logic [ADDR_W-1:0] wrCount_q, wrCount_d;
  logic              memReq_q, memReq_d;
  logic [DATA_W-1:0] memData_q, memData_d;
  logic [ADDR_W-1:0] memAddr_q, memAddr_d;
  logic              done_q, done_d;
  logic              overflow_q, overflow_d;
  logic              fault_q, fault_d;

  logic              errAbort;
  logic              startCapture;
  logic              adcAccept;
  logic              sampleDrop;
  logic              drainDone;
  logic              fifoPush;
  logic              fifoPop;
  logic              fifoFull;
  logic              fifoEmpty;
  logic [DATA_W-1:0] fifoDout;
  logic [FIFO_AW:0]  fifoCount;

  // A dropped sample still counts as accepted so the capture length is fixed.
  assign Active_o     = (capState_q != IDLE);
  assign errAbort     = Active_o && Mem.MemErr;
  assign startCapture = (capState_q == IDLE) && Start_i;
  assign adcAccept    = (capState_q == CAPTURE) && AdcValid_i && !errAbort;
  assign fifoPush     = adcAccept && (!fifoFull || fifoPop);
  assign sampleDrop   = adcAccept && fifoFull && !fifoPop;
  assign drainDone    = (fifoCount == '0) && (wrState_q == W_IDLE) &&
                        ((wrCount_q + dropCnt_q) == length_q);

  assign Done_o         = done_q;
  assign Overflow_o     = overflow_q;
  assign Fault_o        = fault_q;
  assign WrCount_o      = wrCount_q;
  assign Mem.MemData    = memData_q;
  assign Mem.MemAddress = memAddr_q;
  assign Mem.MemReq     = memReq_q;
  assign Mem.MemWnR     = 1'b1;

  sync_fifo #(
    .DATA_W  (DATA_W),
    .FIFO_AW (FIFO_AW)
  ) u_fifo (
    .Clk     (Clk),
    .Reset   (Reset),
    .clear_i (errAbort),
    .push_i  (fifoPush),
    .pop_i   (fifoPop),
    .din_i   (AdcData_i),
    .dout_o  (fifoDout),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .count_o (fifoCount)
  );

  // Capture sequencing: latch on Start, count accepted/dropped samples, detect completion.
  always_comb begin
    capState_d  = capState_q;
    baseAddr_d  = baseAddr_q;
    length_d    = length_q;
    acceptCnt_d = acceptCnt_q;
    dropCnt_d   = dropCnt_q;
    overflow_d  = overflow_q;
    fault_d     = fault_q;
    done_d      = 1'b0;
    if (errAbort) begin
      capState_d = IDLE;
      fault_d    = 1'b1;
    end else begin
      case (capState_q)
        IDLE: begin
          if (Start_i) begin
            baseAddr_d  = BaseAddr_i;
            length_d    = Length_i;
            acceptCnt_d = '0;
            dropCnt_d   = '0;
            overflow_d  = 1'b0;
            fault_d     = 1'b0;
            capState_d  = CAPTURE;
          end
        end
        CAPTURE: begin
          if (adcAccept) begin
            acceptCnt_d = acceptCnt_q + 1'b1;
            if (sampleDrop) begin
              dropCnt_d  = dropCnt_q + 1'b1;
              overflow_d = 1'b1;
            end
            if ((acceptCnt_q + 1'b1) == length_q) capState_d = DRAIN;
          end
        end
        DRAIN: begin
          if (drainDone) begin
            capState_d = IDLE;
            done_d     = 1'b1;
          end
        end
        default: capState_d = IDLE;
      endcase
    end
  end

  // SDRAM write handshake: Req drops on the edge where Ack is first seen to avoid a duplicate write.
  always_comb begin
    wrState_d = wrState_q;
    wrCount_d = wrCount_q;
    memReq_d  = memReq_q;
    memData_d = memData_q;
    memAddr_d = memAddr_q;
    fifoPop   = 1'b0;
    if (errAbort) begin
      wrState_d = W_IDLE;
      memReq_d  = 1'b0;
    end else begin
      if (startCapture) wrCount_d = '0;
      case (wrState_q)
        W_IDLE: begin
          if (!fifoEmpty && !Mem.MemBusy && !Mem.MemAck) begin
            fifoPop   = 1'b1;
            memData_d = fifoDout;
            memAddr_d = baseAddr_q + wrCount_q;
            memReq_d  = 1'b1;
            wrState_d = W_REQ;
          end
        end
        W_REQ: begin
          if (Mem.MemAck) begin
            memReq_d  = 1'b0;
            wrCount_d = wrCount_q + 1'b1;
            wrState_d = W_HOLD;
          end
        end
        W_HOLD: begin
          if (!Mem.MemAck) wrState_d = W_IDLE;
        end
        default: wrState_d = W_IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      capState_q  <= IDLE;
      wrState_q   <= W_IDLE;
      baseAddr_q  <= '0;
      length_q    <= '0;
      acceptCnt_q <= '0;
      dropCnt_q   <= '0;
      wrCount_q   <= '0;
      memReq_q    <= 1'b0;
      memData_q   <= '0;
      memAddr_q   <= '0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      capState_q  <= capState_d;
      wrState_q   <= wrState_d;
      baseAddr_q  <= baseAddr_d;
      length_q    <= length_d;
      acceptCnt_q <= acceptCnt_d;
      dropCnt_q   <= dropCnt_d;
      wrCount_q   <= wrCount_d;
      memReq_q    <= memReq_d;
      memData_q   <= memData_d;
      memAddr_q   <= memAddr_d;
      done_q      <= done_d;
      overflow_q  <= overflow_d;
      fault_q     <= fault_d;
    end
  end

endmodule

// File: tb/tb_adc_capture_writer.sv
// Self-checking bench for adc_capture_writer with a behavioural SDRAM responder.
module tb_adc_capture_writer;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [21:0] BaseAddr = '0;
  logic [21:0] Length = '0;
  logic [15:0] AdcData = '0;
  logic        AdcValid = 1'b0;
  logic        Active;
  logic        Done;
  logic        Overflow;
  logic        Fault;
  logic [21:0] WrCount;

  int errors = 0;
  int checks = 0;
  int doneCount = 0;

  logic [15:0] samples[$];
  logic [21:0] gotAddr[$];
  logic [15:0] gotData[$];
  logic        gotWnR[$];

  int ackLat = 1;
  int holdCnt = 0;
  int waitCnt = 0;
  bit pend = 1'b0;

  adc_capture_writer_if #(.DATA_W(16), .ADDR_W(22)) memIf ();

  adc_capture_writer #(.DATA_W(16), .ADDR_W(22), .FIFO_AW(4)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Start_i    (Start),
    .BaseAddr_i (BaseAddr),
    .Length_i   (Length),
    .AdcData_i  (AdcData),
    .AdcValid_i (AdcValid),
    .Active_o   (Active),
    .Done_o     (Done),
    .Overflow_o (Overflow),
    .Fault_o    (Fault),
    .WrCount_o  (WrCount),
    .Mem        (memIf)
  );

  always #5 Clk = ~Clk;

  // SDRAM responder: logs each new request, acks after ackLat cycles, holds Ack two cycles.
  always @(posedge Clk) begin
    if (Reset) begin
      memIf.MemAck <= 1'b0;
      holdCnt <= 0;
      waitCnt <= 0;
      pend <= 1'b0;
    end else if (holdCnt != 0) begin
      holdCnt <= holdCnt - 1;
      if (holdCnt == 1) memIf.MemAck <= 1'b0;
    end else if (pend) begin
      if (waitCnt <= 1) begin
        memIf.MemAck <= 1'b1;
        holdCnt <= 2;
        pend <= 1'b0;
      end else begin
        waitCnt <= waitCnt - 1;
      end
    end else if (memIf.MemReq === 1'b1) begin
      gotAddr.push_back(memIf.MemAddress);
      gotData.push_back(memIf.MemData);
      gotWnR.push_back(memIf.MemWnR);
      if (ackLat <= 1) begin
        memIf.MemAck <= 1'b1;
        holdCnt <= 2;
      end else begin
        pend <= 1'b1;
        waitCnt <= ackLat - 1;
      end
    end
  end

  // Count Done pulses away from the active edge.
  always @(negedge Clk) begin
    if (Done === 1'b1) doneCount <= doneCount + 1;
  end

  function automatic logic [21:0] expAddr(input logic [21:0] base, input int i);
    return 22'(base + 22'(i));
  endfunction

  task automatic clearLog();
    gotAddr.delete();
    gotData.delete();
    gotWnR.delete();
  endtask

  task automatic makeSamples(input int n);
    samples.delete();
    for (int i = 0; i < n; i++) samples.push_back(16'($urandom));
  endtask

  task automatic startCapture(input logic [21:0] base, input logic [21:0] len);
    BaseAddr = base;
    Length = len;
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    BaseAddr = 22'($urandom);
    Length = 22'($urandom);
  endtask

  task automatic feed(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      AdcData = samples[i];
      AdcValid = 1'b1;
      @(negedge Clk);
      AdcValid = 1'b0;
      AdcData = 16'($urandom);
      for (int k = 1; k < gap; k++) @(negedge Clk);
    end
  endtask

  task automatic waitDone(input int budget, output bit ok);
    int start;
    start = doneCount;
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (doneCount > start) begin
        ok = 1'b1;
        break;
      end
      @(negedge Clk);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge Clk);
    checks++; if (Active !== 1'b0) begin errors++; $display("[TB] FAIL reset_active: got %0h expected 0", Active); end
    checks++; if (Done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %0h expected 0", Done); end
    checks++; if (Overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow: got %0h expected 0", Overflow); end
    checks++; if (Fault !== 1'b0) begin errors++; $display("[TB] FAIL reset_fault: got %0h expected 0", Fault); end
    checks++; if (WrCount !== 22'd0) begin errors++; $display("[TB] FAIL reset_wrcount: got %0h expected 0", WrCount); end
    checks++; if (memIf.MemReq !== 1'b0) begin errors++; $display("[TB] FAIL reset_memreq: got %0h expected 0", memIf.MemReq); end
    checks++; if (memIf.MemAddress !== 22'd0) begin errors++; $display("[TB] FAIL reset_memaddr: got %0h expected 0", memIf.MemAddress); end
    checks++; if (memIf.MemData !== 16'd0) begin errors++; $display("[TB] FAIL reset_memdata: got %0h expected 0", memIf.MemData); end
    checks++; if (memIf.MemWnR !== 1'b1) begin errors++; $display("[TB] FAIL reset_memwnr: got %0h expected 1", memIf.MemWnR); end
    Reset = 1'b0;
    repeat (2) @(negedge Clk);
    checks++; if (Active !== 1'b0) begin errors++; $display("[TB] FAIL idle_active: got %0h expected 0", Active); end
  endtask

  task automatic test_basic();
    bit ok;
    int d0;
    samples.delete();
    for (int i = 0; i < 4; i++) samples.push_back(16'(16'hA000 + i));
    clearLog();
    ackLat = 1;
    d0 = doneCount;
    startCapture(22'h000100, 22'd4);
    feed(4, 4);
    waitDone(2000, ok);
    repeat (5) @(negedge Clk);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL basic_done: got timeout expected Done"); end
    checks++; if (doneCount - d0 !== 1) begin errors++; $display("[TB] FAIL basic_done_once: got %0d pulses expected 1", doneCount - d0); end
    checks++; if (gotAddr.size() !== 4) begin errors++; $display("[TB] FAIL basic_nwrites: got %0d expected 4", gotAddr.size()); end
    for (int i = 0; i < 4 && i < gotAddr.size(); i++) begin
      checks++; if (gotAddr[i] !== expAddr(22'h000100, i)) begin errors++; $display("[TB] FAIL basic_addr[%0d]: got %0h expected %0h", i, gotAddr[i], expAddr(22'h000100, i)); end
      checks++; if (gotData[i] !== samples[i]) begin errors++; $display("[TB] FAIL basic_data[%0d]: got %0h expected %0h", i, gotData[i], samples[i]); end
      checks++; if (gotWnR[i] !== 1'b1) begin errors++; $display("[TB] FAIL basic_wnr[%0d]: got %0h expected 1", i, gotWnR[i]); end
    end
    checks++; if (WrCount !== 22'd4) begin errors++; $display("[TB] FAIL basic_wrcount: got %0h expected 4", WrCount); end
    checks++; if (Overflow !== 1'b0) begin errors++; $display("[TB] FAIL basic_overflow: got %0h expected 0", Overflow); end
    checks++; if (Active !== 1'b0) begin errors++; $display("[TB] FAIL basic_active: got %0h expected 0", Active); end
  endtask

  task automatic test_random();
    bit ok;
    int d0, len, gap;
    logic [21:0] base;
    for (int it = 0; it < 5; it++) begin
      base = 22'($urandom);
      len = $urandom_range(1, 16);
      gap = $urandom_range(4, 8);
      ackLat = $urandom_range(1, 3);
      makeSamples(len);
      clearLog();
      d0 = doneCount;
      startCapture(base, 22'(len));
      feed(len, gap);
      waitDone(3000, ok);
      repeat (5) @(negedge Clk);
      checks++; if (!ok) begin errors++; $display("[TB] FAIL rand%0d_done: got timeout expected Done", it); end
      checks++; if (doneCount - d0 !== 1) begin errors++; $display("[TB] FAIL rand%0d_done_once: got %0d expected 1", it, doneCount - d0); end
      checks++; if (gotAddr.size() !== len) begin errors++; $display("[TB] FAIL rand%0d_nwrites: got %0d expected %0d", it, gotAddr.size(), len); end
      for (int i = 0; i < len && i < gotAddr.size(); i++) begin
        checks++; if (gotAddr[i] !== expAddr(base, i)) begin errors++; $display("[TB] FAIL rand%0d_addr[%0d]: got %0h expected %0h", it, i, gotAddr[i], expAddr(base, i)); end
        checks++; if (gotData[i] !== samples[i]) begin errors++; $display("[TB] FAIL rand%0d_data[%0d]: got %0h expected %0h", it, i, gotData[i], samples[i]); end
      end
      checks++; if (WrCount !== 22'(len)) begin errors++; $display("[TB] FAIL rand%0d_wrcount: got %0h expected %0h", it, WrCount, len); end
      checks++; if (Overflow !== 1'b0) begin errors++; $display("[TB] FAIL rand%0d_overflow: got %0h expected 0", it, Overflow); end
    end
  endtask

  task automatic test_wrap();
    bit ok;
    logic [21:0] exp [0:3];
    exp[0] = 22'h3FFFFE; exp[1] = 22'h3FFFFF; exp[2] = 22'h000000; exp[3] = 22'h000001;
    makeSamples(4);
    clearLog();
    ackLat = 2;
    startCapture(22'h3FFFFE, 22'd4);
    feed(4, 5);
    waitDone(2000, ok);
    repeat (5) @(negedge Clk);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL wrap_done: got timeout expected Done"); end
    checks++; if (gotAddr.size() !== 4) begin errors++; $display("[TB] FAIL wrap_nwrites: got %0d expected 4", gotAddr.size()); end
    for (int i = 0; i < 4 && i < gotAddr.size(); i++) begin
      checks++; if (gotAddr[i] !== exp[i]) begin errors++; $display("[TB] FAIL wrap_addr[%0d]: got %0h expected %0h", i, gotAddr[i], exp[i]); end
      checks++; if (gotData[i] !== samples[i]) begin errors++; $display("[TB] FAIL wrap_data[%0d]: got %0h expected %0h", i, gotData[i], samples[i]); end
    end
  endtask

  task automatic test_overflow();
    bit ok;
    int d0;
    makeSamples(20);
    clearLog();
    ackLat = 2;
    memIf.MemBusy = 1'b1;
    d0 = doneCount;
    startCapture(22'h002000, 22'd20);
    feed(20, 1);
    repeat (3) @(negedge Clk);
    checks++; if (Overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_flag: got %0h expected 1", Overflow); end
    checks++; if (gotAddr.size() !== 0) begin errors++; $display("[TB] FAIL ovf_busy_writes: got %0d expected 0", gotAddr.size()); end
    checks++; if (Active !== 1'b1) begin errors++; $display("[TB] FAIL ovf_active: got %0h expected 1", Active); end
    memIf.MemBusy = 1'b0;
    waitDone(3000, ok);
    repeat (5) @(negedge Clk);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL ovf_done: got timeout expected Done"); end
    checks++; if (doneCount - d0 !== 1) begin errors++; $display("[TB] FAIL ovf_done_once: got %0d expected 1", doneCount - d0); end
    checks++; if (gotAddr.size() !== 16) begin errors++; $display("[TB] FAIL ovf_nwrites: got %0d expected 16", gotAddr.size()); end
    for (int i = 0; i < 16 && i < gotAddr.size(); i++) begin
      checks++; if (gotAddr[i] !== expAddr(22'h002000, i)) begin errors++; $display("[TB] FAIL ovf_addr[%0d]: got %0h expected %0h", i, gotAddr[i], expAddr(22'h002000, i)); end
      checks++; if (gotData[i] !== samples[i]) begin errors++; $display("[TB] FAIL ovf_data[%0d]: got %0h expected %0h", i, gotData[i], samples[i]); end
    end
    checks++; if (WrCount !== 22'd16) begin errors++; $display("[TB] FAIL ovf_wrcount: got %0h expected 10", WrCount); end
    checks++; if (Overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_sticky: got %0h expected 1", Overflow); end
  endtask

  task automatic test_start_in_drain();
    bit ok;
    int d0;
    makeSamples(3);
    clearLog();
    ackLat = 1;
    memIf.MemBusy = 1'b1;
    d0 = doneCount;
    startCapture(22'h000200, 22'd3);
    feed(3, 4);
    repeat (2) @(negedge Clk);
    startCapture(22'h003000, 22'd7);
    checks++; if (Active !== 1'b1) begin errors++; $display("[TB] FAIL drain_active: got %0h expected 1", Active); end
    memIf.MemBusy = 1'b0;
    waitDone(2000, ok);
    repeat (5) @(negedge Clk);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL drain_done: got timeout expected Done"); end
    checks++; if (doneCount - d0 !== 1) begin errors++; $display("[TB] FAIL drain_done_once: got %0d expected 1", doneCount - d0); end
    checks++; if (gotAddr.size() !== 3) begin errors++; $display("[TB] FAIL drain_nwrites: got %0d expected 3", gotAddr.size()); end
    for (int i = 0; i < 3 && i < gotAddr.size(); i++) begin
      checks++; if (gotAddr[i] !== expAddr(22'h000200, i)) begin errors++; $display("[TB] FAIL drain_addr[%0d]: got %0h expected %0h", i, gotAddr[i], expAddr(22'h000200, i)); end
      checks++; if (gotData[i] !== samples[i]) begin errors++; $display("[TB] FAIL drain_data[%0d]: got %0h expected %0h", i, gotData[i], samples[i]); end
    end
    checks++; if (WrCount !== 22'd3) begin errors++; $display("[TB] FAIL drain_wrcount: got %0h expected 3", WrCount); end
  endtask

  task automatic test_mem_err();
    bit ok;
    bit seen;
    int d0;
    makeSamples(8);
    clearLog();
    ackLat = 3;
    d0 = doneCount;
    startCapture(22'h001000, 22'd8);
    fork
      feed(8, 4);
      begin
        seen = 1'b0;
        for (int c = 0; c < 500; c++) begin
          if (gotAddr.size() >= 3) begin seen = 1'b1; break; end
          @(negedge Clk);
        end
        checks++; if (!seen) begin errors++; $display("[TB] FAIL err_third_req: got timeout expected request"); end
        memIf.MemErr = 1'b1;
        @(negedge Clk);
        memIf.MemErr = 1'b0;
        checks++; if (memIf.MemReq !== 1'b0) begin errors++; $display("[TB] FAIL err_memreq: got %0h expected 0", memIf.MemReq); end
        checks++; if (Active !== 1'b0) begin errors++; $display("[TB] FAIL err_active: got %0h expected 0", Active); end
        checks++; if (Fault !== 1'b1) begin errors++; $display("[TB] FAIL err_fault: got %0h expected 1", Fault); end
        checks++; if (WrCount !== 22'd2) begin errors++; $display("[TB] FAIL err_wrcount: got %0h expected 2", WrCount); end
      end
    join
    repeat (20) @(negedge Clk);
    checks++; if (doneCount !== d0) begin errors++; $display("[TB] FAIL err_no_done: got %0d expected %0d", doneCount, d0); end
    checks++; if (gotAddr.size() !== 3) begin errors++; $display("[TB] FAIL err_flushed: got %0d writes expected 3", gotAddr.size()); end
    checks++; if (Fault !== 1'b1) begin errors++; $display("[TB] FAIL err_fault_sticky: got %0h expected 1", Fault); end
    makeSamples(2);
    clearLog();
    ackLat = 1;
    startCapture(22'h000040, 22'd2);
    checks++; if (Fault !== 1'b0) begin errors++; $display("[TB] FAIL err_fault_clear: got %0h expected 0", Fault); end
    feed(2, 4);
    waitDone(2000, ok);
    repeat (5) @(negedge Clk);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL err_recover_done: got timeout expected Done"); end
    checks++; if (gotAddr.size() !== 2) begin errors++; $display("[TB] FAIL err_recover_nwrites: got %0d expected 2", gotAddr.size()); end
  endtask

  task automatic test_reset_abort();
    bit seen;
    makeSamples(18);
    clearLog();
    ackLat = 1;
    memIf.MemBusy = 1'b1;
    startCapture(22'h005000, 22'd20);
    feed(18, 1);
    repeat (2) @(negedge Clk);
    checks++; if (Overflow !== 1'b1) begin errors++; $display("[TB] FAIL rst_pre_overflow: got %0h expected 1", Overflow); end
    memIf.MemBusy = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (gotAddr.size() >= 2 && memIf.MemReq === 1'b1) begin seen = 1'b1; break; end
      @(negedge Clk);
    end
    checks++; if (!seen) begin errors++; $display("[TB] FAIL rst_req_wait: got timeout expected MemReq"); end
    Reset = 1'b1;
    @(negedge Clk);
    checks++; if (memIf.MemReq !== 1'b0) begin errors++; $display("[TB] FAIL rst_memreq: got %0h expected 0", memIf.MemReq); end
    checks++; if (Active !== 1'b0) begin errors++; $display("[TB] FAIL rst_active: got %0h expected 0", Active); end
    checks++; if (WrCount !== 22'd0) begin errors++; $display("[TB] FAIL rst_wrcount: got %0h expected 0", WrCount); end
    checks++; if (Overflow !== 1'b0) begin errors++; $display("[TB] FAIL rst_overflow: got %0h expected 0", Overflow); end
    Reset = 1'b0;
    repeat (10) @(negedge Clk);
    checks++; if (gotAddr.size() !== 2) begin errors++; $display("[TB] FAIL rst_no_more_writes: got %0d expected 2", gotAddr.size()); end
  endtask

  initial begin
    memIf.MemBusy = 1'b0;
    memIf.MemErr = 1'b0;
    test_reset();
    test_basic();
    test_random();
    test_wrap();
    test_overflow();
    test_start_in_drain();
    test_mem_err();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
